// File: rtl/uart_tx_message_sequencer.sv
// Message queue plus byte serialiser for the UART transmitter: each queued message is sent
// LSB byte first, each byte held until busy completes a 0->1->0 handshake.
module uart_tx_message_sequencer #(
    parameter int DATA_WIDTH     = 8,
    parameter int MAX_BYTES      = 4,
    parameter int QUEUE_DEPTH    = 2,
    parameter int GAP_CYCLES     = 2,
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int LEN_WIDTH      = 3
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            msg_valid,
    input  logic [DATA_WIDTH*MAX_BYTES-1:0] msg_data,
    input  logic [LEN_WIDTH-1:0]            msg_len,
    input  logic                            transmitter_busy_synchronized,
    output logic                            transmitter_parallel_data_valid,
    output logic [DATA_WIDTH-1:0]           transmitter_parallel_data,
    output logic                            UART_receiver_controller_enable,
    output logic                            msg_overflow,
    output logic                            tx_done,
    output logic                            tx_error
);
    localparam int MSG_W   = DATA_WIDTH * MAX_BYTES;
    localparam int ENTRY_W = LEN_WIDTH + MSG_W;
    localparam int PTR_W   = $clog2(QUEUE_DEPTH);
    localparam int CNT_W   = $clog2(QUEUE_DEPTH + 1);
    localparam int GAP_W   = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam int TO_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    localparam logic [GAP_W-1:0]     GAP_LAST = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    localparam logic [TO_W-1:0]      TO_LAST  = TO_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
    localparam logic [CNT_W-1:0]     DEPTH    = CNT_W'(QUEUE_DEPTH);
    localparam logic [LEN_WIDTH-1:0] LEN_MAX  = LEN_WIDTH'(MAX_BYTES);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SEND, S_GAP} state_t;
    typedef enum logic [1:0] {NO_TX, BEGAN, ENDED} sub_t;

    state_t               r_state, w_state_next;
    sub_t                 r_sub, w_sub_next;
    logic [MSG_W-1:0]     r_shift, w_shift_next;
    logic [LEN_WIDTH-1:0] r_bytes, w_bytes_next;
    logic [GAP_W-1:0]     r_gap_cnt, w_gap_next;
    logic [TO_W-1:0]      r_to_cnt, w_to_next;
    logic                 r_done, w_done_next;
    logic                 r_error, w_error_next;

    logic [ENTRY_W-1:0]   r_queue [QUEUE_DEPTH];
    logic [PTR_W-1:0]     r_wr_ptr, r_rd_ptr;
    logic [CNT_W-1:0]     r_count, w_count_next;
    logic                 r_enable, r_overflow;
    logic                 w_has_room, w_push, w_pop;
    logic [LEN_WIDTH-1:0] w_len_clamped;
    logic [ENTRY_W-1:0]   w_head;

    assign w_has_room    = r_count < DEPTH;
    assign w_push        = msg_valid && w_has_room;
    assign w_pop         = (r_state == S_LOAD);
    assign w_len_clamped = (msg_len == '0 || msg_len > LEN_MAX) ? LEN_MAX : msg_len;
    assign w_count_next  = r_count + CNT_W'(w_push) - CNT_W'(w_pop);
    assign w_head        = r_queue[r_rd_ptr];

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_enable   <= 1'b1;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            r_count    <= w_count_next;
            r_enable   <= w_count_next < DEPTH;
            r_overflow <= msg_valid && !w_has_room;
        end
    end

    // NOTE: queue storage is not reset; the pointers and count alone decide which entries are live.
    always_ff @(posedge clk) begin
        if (w_push) r_queue[r_wr_ptr] <= {w_len_clamped, msg_data};
    end

    always_comb begin
        // NOTE: every next value starts from a default so no path can infer a latch.
        w_state_next = r_state;
        w_sub_next   = r_sub;
        w_shift_next = r_shift;
        w_bytes_next = r_bytes;
        w_gap_next   = r_gap_cnt;
        w_to_next    = r_to_cnt;
        w_done_next  = 1'b0;
        w_error_next = 1'b0;
        case (r_state)
            S_IDLE: if (r_count != '0 && !transmitter_busy_synchronized) w_state_next = S_LOAD;
            S_LOAD: begin
                w_shift_next = w_head[MSG_W-1:0];
                w_bytes_next = w_head[ENTRY_W-1 -: LEN_WIDTH];
                w_sub_next   = NO_TX;
                w_to_next    = '0;
                w_state_next = S_SEND;
            end
            S_SEND: begin
                case (r_sub)
                    NO_TX: begin
                        if (transmitter_busy_synchronized) begin
                            w_sub_next = BEGAN;
                        end else if (TIMEOUT_CYCLES != 0 && r_to_cnt == TO_LAST) begin
                            w_state_next = S_IDLE;
                            w_error_next = 1'b1;
                        end else begin
                            w_to_next = r_to_cnt + 1'b1;
                        end
                    end
                    BEGAN: if (!transmitter_busy_synchronized) w_sub_next = ENDED;
                    ENDED: begin
                        w_shift_next = r_shift >> DATA_WIDTH;
                        w_bytes_next = r_bytes - 1'b1;
                        w_sub_next   = NO_TX;
                        w_to_next    = '0;
                        w_gap_next   = '0;
                        if (r_bytes == LEN_WIDTH'(1)) begin
                            w_state_next = S_IDLE;
                            w_done_next  = 1'b1;
                        end else if (GAP_CYCLES == 0) begin
                            w_state_next = S_SEND;
                        end else begin
                            w_state_next = S_GAP;
                        end
                    end
                    default: w_sub_next = NO_TX;
                endcase
            end
            S_GAP: begin
                if (r_gap_cnt == GAP_LAST) begin
                    w_state_next = S_SEND;
                    w_sub_next   = NO_TX;
                    w_to_next    = '0;
                end else begin
                    w_gap_next = r_gap_cnt + 1'b1;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_sub     <= NO_TX;
            r_shift   <= '0;
            r_bytes   <= '0;
            r_gap_cnt <= '0;
            r_to_cnt  <= '0;
            r_done    <= 1'b0;
            r_error   <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_sub     <= w_sub_next;
            r_shift   <= w_shift_next;
            r_bytes   <= w_bytes_next;
            r_gap_cnt <= w_gap_next;
            r_to_cnt  <= w_to_next;
            r_done    <= w_done_next;
            r_error   <= w_error_next;
        end
    end

    assign transmitter_parallel_data_valid = (r_state == S_SEND);
    assign transmitter_parallel_data       = (r_state == S_SEND) ? r_shift[DATA_WIDTH-1:0] : '0;
    assign UART_receiver_controller_enable = r_enable;
    assign msg_overflow                    = r_overflow;
    assign tx_done                         = r_done;
    assign tx_error                        = r_error;

endmodule
